// File: rtl/space_invaders_pkg.sv
// Shared constants for the invader fleet and sprite_drawer: FSM/direction
// encodings and default geometry/timing parameters.
`timescale 1ns/1ps
package space_invaders_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MARCH   = 2'd1,
        ST_LANDED  = 2'd2,
        ST_CLEARED = 2'd3
    } fleet_state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } fleet_dir_e;

    localparam int COLS_DEF        = 5;
    localparam int ROWS_DEF        = 2;
    localparam int SPACING_DEF     = 2;
    localparam int X_W_DEF         = 5;
    localparam int Y_W_DEF         = 4;
    localparam int X_MAX_DEF       = 31;
    localparam int LAND_LINE_DEF   = 14;
    localparam int PERIOD_BASE_DEF = 1_000_000;
    localparam int PERIOD_PER_DEF  = 200_000;
    localparam int T_W_DEF         = 24;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fleet_extent.sv
// Combinational extent of the surviving fleet: leftmost/rightmost alive
// column, lowest alive row and number of survivors.
`timescale 1ns/1ps
module fleet_extent import space_invaders_pkg::*; #(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int C_W  = clog2_min1(COLS),
    parameter int R_W  = clog2_min1(ROWS),
    parameter int N_W  = $clog2(ROWS*COLS+1)
) (
    input  logic [ROWS*COLS-1:0] alive,
    output logic [C_W-1:0]       min_alive_col,
    output logic [C_W-1:0]       max_alive_col,
    output logic [R_W-1:0]       max_alive_row,
    output logic [N_W-1:0]       alive_count
);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    always_comb begin
        col_any     = '0;
        row_any     = '0;
        alive_count = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                col_any[c]  = col_any[c] | alive[r*COLS+c];
                row_any[r]  = row_any[r] | alive[r*COLS+c];
                alive_count = alive_count + N_W'(alive[r*COLS+c]);
            end
        end
    end

    // Empty fleet reports zero extents; the owner checks alive_count first.
    always_comb begin
        min_alive_col = '0;
        max_alive_col = '0;
        max_alive_row = '0;
        for (int c = COLS-1; c >= 0; c--)
            if (col_any[c]) min_alive_col = C_W'(c);
        for (int c = 0; c < COLS; c++)
            if (col_any[c]) max_alive_col = C_W'(c);
        for (int r = 0; r < ROWS; r++)
            if (row_any[r]) max_alive_row = R_W'(r);
    end

endmodule

// File: rtl/invader_fleet.sv
// Invader fleet: marches the formation left/right and down on a timer that
// speeds up as invaders die, resolves bullet hits and flags landing/clear.
`timescale 1ns/1ps
module invader_fleet import space_invaders_pkg::*; #(
    parameter int COLS        = COLS_DEF,
    parameter int ROWS        = ROWS_DEF,
    parameter int SPACING     = SPACING_DEF,
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int LAND_LINE   = LAND_LINE_DEF,
    parameter int PERIOD_BASE = PERIOD_BASE_DEF,
    parameter int PERIOD_PER  = PERIOD_PER_DEF,
    parameter int T_W         = T_W_DEF
) (
    input  logic                 clk_36MHz,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [X_W-1:0]       bullet_x,
    input  logic [Y_W-1:0]       bullet_y,
    input  logic                 bullet_flying,
    output logic [ROWS*COLS-1:0] invaders_array,
    output logic [X_W-1:0]       fleet_x,
    output logic [Y_W-1:0]       fleet_line,
    output logic                 hit,
    output logic                 landed,
    output logic                 wave_cleared,
    output logic [1:0]           state
);

    localparam int C_W = clog2_min1(COLS);
    localparam int R_W = clog2_min1(ROWS);
    localparam int N_W = $clog2(ROWS*COLS+1);
    localparam int SH  = $clog2(SPACING);
    localparam int E_W = X_W + C_W + SH + 1;
    localparam int L_W = ((Y_W > R_W) ? Y_W : R_W) + 1;

    fleet_state_e st;
    fleet_dir_e   dir;
    logic [T_W-1:0] timer;

    logic [C_W-1:0] min_col, max_col;
    logic [R_W-1:0] max_row;
    logic [N_W-1:0] alive_count;

    fleet_extent #(.COLS(COLS), .ROWS(ROWS)) u_extent (
        .alive         (invaders_array),
        .min_alive_col (min_col),
        .max_alive_col (max_col),
        .max_alive_row (max_row),
        .alive_count   (alive_count)
    );

    // Period follows the live count, so a kill shortens the current run.
    logic [T_W-1:0] period;
    logic           step;
    assign period = T_W'(PERIOD_BASE) + T_W'(alive_count) * T_W'(PERIOD_PER);
    assign step   = timer >= (period - T_W'(1));

    logic [E_W-1:0] left_edge, right_edge;
    logic           landing;
    assign left_edge  = E_W'(fleet_x) + (E_W'(min_col) << SH);
    assign right_edge = E_W'(fleet_x) + (E_W'(max_col) << SH);
    assign landing    = (L_W'(fleet_line) + L_W'(max_row)) >= L_W'(LAND_LINE);

    logic [X_W-1:0]       dx;
    logic [Y_W-1:0]       dy;
    logic [ROWS*COLS-1:0] hit_mask;
    assign dx = bullet_x - fleet_x;
    assign dy = bullet_y - fleet_line;

    // One-hot (or empty) mask of the invader under the bullet; underflow misses.
    always_comb begin
        hit_mask = '0;
        if (bullet_flying && enable && st == ST_MARCH &&
            bullet_x >= fleet_x && bullet_y >= fleet_line &&
            (dx & X_W'(SPACING-1)) == '0) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if ((dx >> SH) == X_W'(c) && dy == Y_W'(r))
                        hit_mask[r*COLS+c] = invaders_array[r*COLS+c];
        end
    end

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            st             <= ST_IDLE;
            dir            <= DIR_RIGHT;
            timer          <= '0;
            invaders_array <= '0;
            fleet_x        <= '0;
            fleet_line     <= '0;
            hit            <= 1'b0;
            landed         <= 1'b0;
            wave_cleared   <= 1'b0;
        end else if (clear) begin
            st             <= ST_MARCH;
            dir            <= DIR_RIGHT;
            timer          <= '0;
            invaders_array <= '1;
            fleet_x        <= '0;
            fleet_line     <= '0;
            hit            <= 1'b0;
            landed         <= 1'b0;
            wave_cleared   <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (st == ST_MARCH) begin
                if (alive_count == '0) begin
                    st           <= ST_CLEARED;
                    wave_cleared <= 1'b1;
                end else if (landing) begin
                    st     <= ST_LANDED;
                    landed <= 1'b1;
                end else if (enable) begin
                    invaders_array <= invaders_array & ~hit_mask;
                    hit            <= |hit_mask;
                    if (step) begin
                        timer <= '0;
                        if (dir == DIR_RIGHT) begin
                            if (right_edge + E_W'(1) <= E_W'(X_MAX)) begin
                                fleet_x <= fleet_x + X_W'(1);
                            end else begin
                                fleet_line <= fleet_line + Y_W'(1);
                                dir        <= DIR_LEFT;
                            end
                        end else begin
                            if (left_edge != '0) begin
                                fleet_x <= fleet_x - X_W'(1);
                            end else begin
                                fleet_line <= fleet_line + Y_W'(1);
                                dir        <= DIR_RIGHT;
                            end
                        end
                    end else begin
                        timer <= timer + T_W'(1);
                    end
                end
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_invader_fleet.sv
// Bench for invader_fleet: directed scenarios plus random bullets/enables,
// all outputs compared every cycle against a cell-level reference model.
`timescale 1ns/1ps
module tb_invader_fleet;
    import space_invaders_pkg::*;

    localparam int COLS = 5, ROWS = 2, SP = 2, X_W = 5, Y_W = 4;
    localparam int X_MAX = 31, LAND = 14, BASE = 4, PER = 1;
    localparam int N = ROWS*COLS;

    logic           clk_36MHz = 1'b0;
    logic           reset, clear, enable, bullet_flying;
    logic [X_W-1:0] bullet_x;
    logic [Y_W-1:0] bullet_y;
    logic [N-1:0]   invaders_array;
    logic [X_W-1:0] fleet_x;
    logic [Y_W-1:0] fleet_line;
    logic           hit, landed, wave_cleared;
    logic [1:0]     state;

    invader_fleet #(.PERIOD_BASE(BASE), .PERIOD_PER(PER)) dut (
        .clk_36MHz(clk_36MHz), .reset(reset), .clear(clear), .enable(enable),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_flying(bullet_flying),
        .invaders_array(invaders_array), .fleet_x(fleet_x), .fleet_line(fleet_line),
        .hit(hit), .landed(landed), .wave_cleared(wave_cleared), .state(state)
    );

    always #5 clk_36MHz = ~clk_36MHz;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one bit per invader cell plus screen position.
    int           m_alive[N];
    int           mx, my, mdir, mtimer, mhit, mland, mclr;
    fleet_state_e mst;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < N; i++) n += m_alive[i];
        return n;
    endfunction

    function automatic logic [N-1:0] m_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_alive[i] != 0);
        return v;
    endfunction

    task automatic m_reload(input int a);
        for (int i = 0; i < N; i++) m_alive[i] = a;
        mx = 0; my = 0; mdir = 0; mtimer = 0; mhit = 0; mland = 0; mclr = 0;
    endtask

    task automatic model_step();
        int cnt, minc, maxc, maxr, ox, oy;
        if (!reset) begin m_reload(0); mst = ST_IDLE; return; end
        if (clear)  begin m_reload(1); mst = ST_MARCH; return; end
        mhit = 0;
        if (mst != ST_MARCH) return;
        cnt = 0; minc = COLS; maxc = -1; maxr = -1;
        for (int i = 0; i < N; i++) if (m_alive[i] != 0) begin
            cnt++;
            if (i % COLS < minc) minc = i % COLS;
            if (i % COLS > maxc) maxc = i % COLS;
            if (i / COLS > maxr) maxr = i / COLS;
        end
        if (cnt == 0) begin mst = ST_CLEARED; mclr = 1; return; end
        if (my + maxr >= LAND) begin mst = ST_LANDED; mland = 1; return; end
        if (!enable) return;
        ox = int'(bullet_x) - mx;
        oy = int'(bullet_y) - my;
        if (bullet_flying && ox >= 0 && oy >= 0 && ox % SP == 0 && ox / SP < COLS &&
            oy < ROWS && m_alive[oy*COLS + ox/SP] != 0) begin
            m_alive[oy*COLS + ox/SP] = 0;
            mhit = 1;
        end
        if (mtimer >= BASE + cnt*PER - 1) begin
            mtimer = 0;
            if (mdir == 0) begin
                if (mx + maxc*SP + 1 <= X_MAX) mx++; else begin my++; mdir = 1; end
            end else begin
                if (mx + minc*SP > 0) mx--; else begin my++; mdir = 0; end
            end
        end else mtimer++;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_36MHz); #1;
        chk("state", state, mst);
        chk("alive", invaders_array, m_vec());
        chk("fleet_x", fleet_x, mx);
        chk("fleet_line", fleet_line, my);
        chk("hit", hit, mhit);
        chk("landed", landed, mland);
        chk("wave_cleared", wave_cleared, mclr);
    endtask

    task automatic aim(input int i);
        bullet_x = X_W'(mx + (i % COLS)*SP);
        bullet_y = Y_W'(my + i / COLS);
    endtask

    task automatic do_clear();
        bullet_flying = 0; clear = 1; cyc(); clear = 0;
    endtask

    initial begin
        int n, sx;
        reset = 0; clear = 0; enable = 1; bullet_flying = 0; bullet_x = '0; bullet_y = '0;
        mst = ST_IDLE; m_reload(0);
        repeat (3) cyc();
        chk("rst_state", state, ST_IDLE);
        chk("rst_alive", invaders_array, 0);

        // IDLE ignores bullets and enable
        reset = 1;
        repeat (5) begin
            bullet_flying = 1; bullet_x = X_W'($urandom); bullet_y = Y_W'($urandom); cyc();
        end
        chk("idle_hold", state, ST_IDLE);

        do_clear();
        chk("clr_state", state, ST_MARCH);
        chk("clr_alive", invaders_array, 10'h3FF);
        repeat (13) cyc();
        chk("pre_step_x", fleet_x, 0);
        cyc();
        chk("first_step_x", fleet_x, 1);

        // right wall turn
        n = 0;
        while (fleet_line != 1 && n < 2000) begin cyc(); n++; end
        chk("wall_timeout", n < 2000, 1);
        chk("wall_x", fleet_x, 23);
        chk("wall_line", fleet_line, 1);
        n = 0;
        while (fleet_x == 23 && n < 40) begin cyc(); n++; end
        chk("left_step_x", fleet_x, 22);

        // single hit and an off-grid miss
        do_clear();
        n = 0;
        while (fleet_x != 3 && n < 100) begin cyc(); n++; end
        chk("x3_timeout", n < 100, 1);
        bullet_x = 5; bullet_y = 1; bullet_flying = 1; cyc(); bullet_flying = 0;
        chk("hit6_pulse", hit, 1);
        chk("hit6_bit", invaders_array[6], 0);
        cyc();
        chk("hit6_one_cycle", hit, 0);
        bullet_x = 6; bullet_y = 1; bullet_flying = 1; cyc(); bullet_flying = 0;
        chk("miss_odd", hit, 0);
        chk("miss_alive", invaders_array, 10'h3BF);

        // wipe out the rest of the wave
        n = 0;
        while (m_count() > 0 && n < 40) begin
            for (int i = N-1; i >= 0; i--) if (m_alive[i] != 0) aim(i);
            bullet_flying = 1; cyc(); n++;
            chk("kill_hit", hit, 1);
        end
        bullet_flying = 0;
        chk("kill_last_pending", wave_cleared, 0);
        cyc();
        chk("cleared_flag", wave_cleared, 1);
        chk("cleared_state", state, ST_CLEARED);
        sx = mx;
        repeat (40) cyc();
        chk("cleared_x_hold", fleet_x, sx);

        // random play
        do_clear();
        for (int k = 0; k < 3000; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            bullet_flying = $urandom_range(0, 1);
            if ($urandom_range(0, 1) != 0) aim($urandom_range(0, N-1));
            else begin bullet_x = X_W'($urandom); bullet_y = Y_W'($urandom); end
            clear = ($urandom_range(0, 399) == 0);
            cyc();
        end
        clear = 0; enable = 1; bullet_flying = 0;

        // march all the way down
        do_clear();
        n = 0;
        while (!landed && n < 6000) begin cyc(); n++; end
        chk("land_timeout", n < 6000, 1);
        chk("land_line", fleet_line, 13);
        chk("land_state", state, ST_LANDED);
        repeat (20) cyc();
        chk("land_hold", fleet_line, 13);
        do_clear();
        chk("reclear_state", state, ST_MARCH);
        chk("reclear_line", fleet_line, 0);
        chk("reclear_landed", landed, 0);

        // reset landing on a hit+step cycle
        n = 0;
        while (mtimer < BASE + m_count()*PER - 1 && n < 40) begin cyc(); n++; end
        aim(0); bullet_flying = 1; reset = 0;
        cyc();
        chk("rst_mid_hit", hit, 0);
        chk("rst_mid_state", state, ST_IDLE);
        chk("rst_mid_alive", invaders_array, 0);
        chk("rst_mid_x", fleet_x, 0);
        reset = 1; bullet_flying = 0;
        repeat (3) cyc();
        chk("idle_after_rst", state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/invader_fleet.md
INVADER_FLEET -- requirements
Module: invader_fleet

Interface
REQ-001 Parameter COLS, default 5: invader columns per row.
REQ-002 Parameter ROWS, default 2: invader rows.
REQ-003 Parameter SPACING, default 2 (power of two): screen columns between adjacent invaders.
REQ-004 Parameter X_W, default 5; Y_W, default 4: grid coordinate widths.
REQ-005 Parameter X_MAX, default 31; LAND_LINE, default 14: right wall column; line at which the fleet has landed.
REQ-006 Parameter PERIOD_BASE, default 1_000_000; PERIOD_PER, default 200_000: step period = PERIOD_BASE + alive_count*PERIOD_PER cycles.
REQ-007 Parameter T_W, default 24: step-timer width; SHALL hold the maximum period.
REQ-008 clk_36MHz  in  1  sole clock.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 clear  in  1  one-cycle request: reload wave and start marching.
REQ-011 enable  in  1  high = timer and hit logic active; low = freeze all state.
REQ-012 bullet_x  in  X_W; bullet_y  in  Y_W; bullet_flying  in  1: player bullet cell and valid.
REQ-013 invaders_array  out  ROWS*COLS  alive bits, row-major, bit r*COLS+c.
REQ-014 fleet_x  out  X_W  screen column of column 0; fleet_line  out  Y_W  line of row 0.
REQ-015 hit  out  1  one-cycle pulse per kill; landed  out  1  level; wave_cleared  out  1  level.
REQ-016 state  out  2  current FSM state, for debug.

Function
REQ-017 FSM states: IDLE, MARCH, LANDED, CLEARED; the encoding SHALL come from the shared package.
REQ-018 clear SHALL, from any state, set every alive bit, fleet_x=0, fleet_line=0, direction=right, timer=0, state=MARCH on the next edge; clear takes priority over every other event in that cycle.
REQ-019 In MARCH with enable=1, the timer SHALL increment each cycle; when timer reaches period-1 it SHALL reset to 0 and a step SHALL occur.
REQ-020 Step right: if right_edge+1 <= X_MAX, fleet_x SHALL increment; otherwise fleet_line SHALL increment and direction SHALL become left. right_edge = fleet_x + max_alive_col*SPACING.
REQ-021 Step left: if left_edge > 0, fleet_x SHALL decrement; otherwise fleet_line SHALL increment and direction SHALL become right. left_edge = fleet_x + min_alive_col*SPACING.
REQ-022 A hit SHALL be detected when bullet_flying=1, state=MARCH, enable=1, bullet_x-fleet_x is a multiple of SPACING with quotient c<COLS, bullet_y-fleet_line = r<ROWS, and bit (r,c) is alive; unsigned underflow SHALL be treated as a miss.
REQ-023 On a hit, bit (r,c) SHALL clear and hit SHALL pulse high for exactly one cycle, both on the next edge; at most one kill per cycle.
REQ-024 A hit and a step in the same cycle SHALL both apply; hit matching SHALL use the pre-step position.
REQ-025 When the alive count becomes 0, state SHALL become CLEARED on the edge following the last kill, and wave_cleared SHALL be 1 from that edge.
REQ-026 When fleet_line + max_alive_row >= LAND_LINE after a step, state SHALL become LANDED on the next edge, and landed SHALL be 1 from that edge; CLEARED takes priority if both conditions hold.
REQ-027 In LANDED and CLEARED, position, alive bits and timer SHALL hold until clear.
REQ-028 A period change caused by a kill SHALL take effect on the current timer run; if timer >= new period-1, a step SHALL occur on the next cycle.
REQ-029 enable=0 SHALL freeze the timer, position and alive bits, and suppress hit.

Reset
REQ-030 reset low SHALL asynchronously force: state=IDLE, invaders_array=0, fleet_x=0, fleet_line=0, direction=right, timer=0, hit=0, landed=0, wave_cleared=0.
REQ-031 A reset asserted mid-step or mid-hit SHALL leave no partial update.
REQ-032 IDLE SHALL be left only by clear.

Structure
REQ-033 Package space_invaders_pkg SHALL hold the FSM state constants, the direction constants and the parameter defaults shared with sprite_drawer.
REQ-034 Sub-module fleet_extent SHALL combinationally produce min_alive_col, max_alive_col, max_alive_row and alive_count from invaders_array.
REQ-035 All outputs SHALL be registered.

Verification (overrides: PERIOD_BASE=4, PERIOD_PER=1, defaults otherwise)
REQ-036 reset low, then clear pulse -> state=MARCH, invaders_array=10'h3FF; first step after 14 cycles gives fleet_x=1.
REQ-037 March right -> at fleet_x=23 (right_edge 31) the next step gives fleet_line=1, fleet_x=23, direction=left.
REQ-038 fleet_x=3, fleet_line=0, bullet (5,1) flying -> bit 6 clears, hit high for one cycle; bullet (6,1) -> no hit.
REQ-039 Kill all 10 invaders -> wave_cleared=1 one cycle after the 10th hit; fleet_x holds thereafter.
REQ-040 Fleet reaching fleet_line=13 with row 1 alive -> landed=1; clear then gives MARCH with fleet_line=0.
REQ-041 reset asserted in the same cycle as a hit and a step -> all outputs take their reset values, and no hit pulse appears.
